// File: rtl/output_arbiter.sv
// Per-output-port arbiter with a two-slot (EVEN/ODD) virtual-channel output stage.
// Latency: grant is combinational; the flit is captured at the end of the grant cycle, earliest sendO the next cycle.
// Backpressure: receiveO=0 holds the drain slot FULL; a FULL fill slot forces grant=0 (optional macro OUTPUT_ARBITER_FIXED_PRIO_EN).
module output_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          polarity,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          receiveO,
  output logic                          sendO,
  output logic [DATA_WIDTH-1:0]         dataO
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Index 0 is the EVEN slot, index 1 the ODD slot.
  slot_state_e           state_q [2];
  slot_state_e           state_d [2];
  logic [DATA_WIDTH-1:0] dat_q   [2];
  logic [DATA_WIDTH-1:0] dat_d   [2];
`ifndef OUTPUT_ARBITER_FIXED_PRIO_EN
  logic [PTR_W-1:0]      ptr_q   [2];
  logic [PTR_W-1:0]      ptr_d   [2];
  logic [PTR_W-1:0]      gnt_idx;
`endif

  logic                  fill_sel;
  logic                  drain_sel;
  logic                  gnt_vld;
  logic [NUM_REQ-1:0]    gnt_vec;
  logic [DATA_WIDTH-1:0] gnt_dat;
  logic                  drain_full;

  // polarity picks which slot fills and which drains; they are always different slots.
  assign fill_sel   = polarity;
  assign drain_sel  = ~polarity;
  assign drain_full = (state_q[drain_sel] == SLOT_FULL);

  // Pick the first requester starting at the fill slot's pointer (or at 0 for fixed priority).
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_vec = '0;
    gnt_dat = '0;
`ifndef OUTPUT_ARBITER_FIXED_PRIO_EN
    gnt_idx = '0;
`endif
    if (state_q[fill_sel] == SLOT_EMPTY) begin
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef OUTPUT_ARBITER_FIXED_PRIO_EN
        idx = k;
`else
        idx = (int'(ptr_q[fill_sel]) + k) % NUM_REQ;
`endif
        if (!gnt_vld && req[idx]) begin
          gnt_vld      = 1'b1;
          gnt_vec[idx] = 1'b1;
          gnt_dat      = data_in[idx*DATA_WIDTH +: DATA_WIDTH];
`ifndef OUTPUT_ARBITER_FIXED_PRIO_EN
          gnt_idx      = PTR_W'(idx);
`endif
        end
      end
    end
  end

  // Outputs are forced low while reset is asserted so they drop without waiting for a clock edge.
  assign grant = rst ? gnt_vec : '0;
  assign sendO = rst & drain_full & receiveO;
  assign dataO = (rst && drain_full) ? dat_q[drain_sel] : '0;

  // Next state: the fill slot captures a granted flit, the drain slot empties on a transfer.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      state_d[s] = state_q[s];
      dat_d[s]   = dat_q[s];
`ifndef OUTPUT_ARBITER_FIXED_PRIO_EN
      ptr_d[s]   = ptr_q[s];
`endif
    end
    if (gnt_vld) begin
      state_d[fill_sel] = SLOT_FULL;
      dat_d[fill_sel]   = gnt_dat;
`ifndef OUTPUT_ARBITER_FIXED_PRIO_EN
      ptr_d[fill_sel]   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
    end
    if (sendO) begin
      state_d[drain_sel] = SLOT_EMPTY;
    end
  end

  // Slot state, data and pointer registers; reset discards any in-flight flit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= SLOT_EMPTY;
        dat_q[s]   <= '0;
`ifndef OUTPUT_ARBITER_FIXED_PRIO_EN
        ptr_q[s]   <= '0;
`endif
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= state_d[s];
        dat_q[s]   <= dat_d[s];
`ifndef OUTPUT_ARBITER_FIXED_PRIO_EN
        ptr_q[s]   <= ptr_d[s];
`endif
      end
    end
  end

endmodule

// File: doc/output_arbiter.md
# output_arbiter

Per-output-port arbiter and two-slot virtual-channel output stage of the router. Takes the `sig_req_channel` lines of all input controllers competing for one output port, grants at most one per cycle via `sig_channel_clean`, latches the granted flit into the even or odd output slot according to `polarity`, and forwards it downstream with a `sendO`/`receiveO` handshake. It is instantiated once per output port, between the input controllers and the link to the neighbour node.

## Interface
- `NUM_REQ`, 4: number of requesting input controllers (≥2).
- `DATA_WIDTH`, 64: flit width.
- `PTR_W`, `$clog2(NUM_REQ)`: round-robin pointer width (derived, not overridden).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `polarity`  in  1  router-global phase; 0 = even phase, 1 = odd phase.
- `req`  in  NUM_REQ  request from input controller i (its `sig_req_channel`).
- `data_in`  in  NUM_REQ*DATA_WIDTH  flits, requester i at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `grant`  out  NUM_REQ  one-hot grant to requester i (drives its `sig_channel_clean`).
- `receiveO`  in  1  downstream node can accept a flit this cycle.
- `sendO`  out  1  flit on `dataO` is being transferred this cycle.
- `dataO`  out  DATA_WIDTH  outgoing flit.

## Operation
- Two slots, EVEN and ODD, each with `valid` plus a DATA_WIDTH register; per-slot state EMPTY/FULL.
- Phase roles: `polarity`=0 → EVEN is fill slot, ODD is drain slot. `polarity`=1 → ODD fills, EVEN drains. A slot is never filled and drained in the same cycle.
- Grant (combinational): if fill slot EMPTY and `req`≠0, `grant` = one-hot of the first requester with `req`=1, searching from the fill slot's pointer upward with wrap at NUM_REQ-1→0. Otherwise `grant`=0.
- Fill (clock edge): on grant to i, fill slot ← `data_in[i]`, state → FULL, that slot's pointer ← (i+1) mod NUM_REQ. Each slot has its own pointer; the other slot's pointer holds.
- Drain: `sendO` = drain slot FULL && `receiveO`; `dataO` = drain slot data whenever the slot is FULL, else 0. On the edge with `sendO`=1, the drain slot → EMPTY. The data register may hold its stale value.
- FULL fill slot: `grant`=0 regardless of `req`. Requests stall with no loss.
- `receiveO`=0: drain slot stays FULL and `sendO`=0.
- Reset (asserted at any time, including mid-transfer): both slots EMPTY, data regs 0, pointers 0. `grant`, `sendO`, and `dataO` fall to 0 immediately, without waiting for `clk`. An in-flight flit is discarded.

## Timing
- Reset values: `grant`=0, `sendO`=0, `dataO`=0.
- Grant latency: same cycle as `req` (combinational from `req`, `polarity`, slot state, pointer).
- Capture: flit is in the slot on the edge ending the grant cycle.
- Earliest `sendO`: next cycle, once `polarity` has toggled so that slot becomes the drain slot. Minimum `req`→`sendO` is 1 cycle.
- Throughput: one flit per cycle with `polarity` alternating and `receiveO`=1.
- No combinational path from `receiveO` to `grant`.

## Configuration
- `OUTPUT_ARBITER_FIXED_PRIO_EN`
  - Defined: fixed priority. Lowest requester index wins. Pointers are not implemented and fill does not update any pointer.
  - Undefined (default): round-robin as described in Operation.
  - All other behaviour is identical in both builds.

## Test plan
- **Reset:** hold `rst`=0 with `req`=4'b1111 and `receiveO`=1 → `grant`=0, `sendO`=0, `dataO`=0. Assert `rst`=0 mid-cycle while `sendO`=1 → `sendO` drops before the next edge.
- **Single flit:** `polarity`=0, `req`=4'b0100, `data_in[2]`=64'hA5A5 → `grant`=4'b0100 that cycle. Next cycle with `polarity`=1 and `receiveO`=1 → `sendO`=1, `dataO`=64'hA5A5. One cycle later EVEN is empty and `sendO`=0.
- **Round-robin:** `req`=4'b1111 held, `receiveO`=1, `polarity` toggling → EVEN grants 0,1,2,3,0 and ODD grants 0,1,2,3,0 independently. With the macro defined, every grant is 4'b0001.
- **Backpressure:** `receiveO`=0 for 6 cycles with `req`=4'b0011 → each slot fills once (2 grants total), then `grant`=0. When `receiveO`=1, the flits drain in order EVEN, ODD per phase and granting resumes.
- **Pointer wrap:** EVEN pointer=3 and `req`=4'b1001 → grant 3, pointer → 0. Next EVEN fill phase → grant 0.
- **Overlap:** ODD FULL, `polarity`=0, `receiveO`=1, `req`=4'b0010 in the same cycle → `sendO`=1 from ODD and `grant`=4'b0010 filling EVEN, with no corruption of either slot.
